// File: rtl/bram_load_ctrl.sv
// Streams words into NUMBER_SUPPORTED_FILTERS BRAM banks, filling each bank from address 0 up to a latched max.
// Optional abort input is enabled by defining BRAM_LOAD_CTRL_ABORT_EN.
module bram_load_ctrl #(
    parameter int NUMBER_SUPPORTED_FILTERS = 30,
    parameter int BRAM_ADDR_WIDTH          = 11,
    parameter int DATA_WIDTH               = 16
) (
    input  logic                                        clk_i,
    input  logic                                        general_rst_n_i,
    input  logic                                        order_load_bram_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]                  bram_addr_max_i,
`ifdef BRAM_LOAD_CTRL_ABORT_EN
    input  logic                                        abort_i,
`endif
    input  logic                                        data_valid_i,
    input  logic [DATA_WIDTH-1:0]                       data_i,
    output logic                                        data_ready_o,
    output logic [NUMBER_SUPPORTED_FILTERS-1:0]         bram_wr_en_o,
    output logic [BRAM_ADDR_WIDTH-1:0]                  bram_addr_o,
    output logic [DATA_WIDTH-1:0]                       bram_data_o,
    output logic [$clog2(NUMBER_SUPPORTED_FILTERS)-1:0] sel_filter_o,
    output logic                                        bram_ready_o,
    output logic                                        load_done_o
);

    localparam int FW = $clog2(NUMBER_SUPPORTED_FILTERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [BRAM_ADDR_WIDTH-1:0]    max_r;
    logic [BRAM_ADDR_WIDTH-1:0]    addr_cnt_r;
    logic [FW-1:0]                 filt_cnt_r;
    logic [NUMBER_SUPPORTED_FILTERS-1:0] wr_en_r;
    logic [BRAM_ADDR_WIDTH-1:0]    addr_r;
    logic [DATA_WIDTH-1:0]         data_r;
    logic [FW-1:0]                 sel_r;
    logic                          data_ready_r;
    logic                          bram_ready_r;
    logic                          load_done_r;
    logic                          abort_s;
    logic                          xfer_s;
    logic                          addr_last_s;
    logic                          filt_last_s;

    function automatic logic [NUMBER_SUPPORTED_FILTERS-1:0] onehot_f(input logic [FW-1:0] idx);
        logic [NUMBER_SUPPORTED_FILTERS-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

`ifdef BRAM_LOAD_CTRL_ABORT_EN
    assign abort_s = abort_i && ((state_r == LATCH) || (state_r == LOAD));
`else
    assign abort_s = 1'b0;
`endif

    assign xfer_s      = data_valid_i && (state_r == LOAD) && !abort_s;
    assign addr_last_s = (addr_cnt_r == max_r);
    assign filt_last_s = (filt_cnt_r == FW'(NUMBER_SUPPORTED_FILTERS - 1));

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (order_load_bram_i) begin
                    state_next_s = LATCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LATCH: begin
                if (abort_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOAD;
                end
            end
            LOAD: begin
                if (abort_s) begin
                    state_next_s = IDLE;
                end else if (xfer_s && addr_last_s && filt_last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = LOAD;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register and status flags, registered from the next state
    always_ff @(posedge clk_i or negedge general_rst_n_i) begin
        if (!general_rst_n_i) begin
            state_r      <= IDLE;
            data_ready_r <= 1'b0;
            bram_ready_r <= 1'b1;
            load_done_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            data_ready_r <= (state_next_s == LOAD);
            bram_ready_r <= (state_next_s == IDLE);
            load_done_r  <= (state_next_s == DONE);
        end
    end

    // Latched max and address/filter counters
    always_ff @(posedge clk_i or negedge general_rst_n_i) begin
        if (!general_rst_n_i) begin
            max_r      <= '0;
            addr_cnt_r <= '0;
            filt_cnt_r <= '0;
        end else if (state_r == LATCH) begin
            max_r      <= bram_addr_max_i;
            addr_cnt_r <= '0;
            filt_cnt_r <= '0;
        end else if (abort_s) begin
            addr_cnt_r <= '0;
            filt_cnt_r <= '0;
        end else if (xfer_s) begin
            if (addr_last_s) begin
                addr_cnt_r <= '0;
                // Counters return to zero after the final word of the final bank
                filt_cnt_r <= filt_last_s ? '0 : filt_cnt_r + FW'(1);
            end else begin
                addr_cnt_r <= addr_cnt_r + BRAM_ADDR_WIDTH'(1);
            end
        end else begin
            addr_cnt_r <= addr_cnt_r;
            filt_cnt_r <= filt_cnt_r;
        end
    end

    // BRAM write port, one cycle behind the accepted word
    always_ff @(posedge clk_i or negedge general_rst_n_i) begin
        if (!general_rst_n_i) begin
            wr_en_r <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            sel_r   <= '0;
        end else if (xfer_s) begin
            wr_en_r <= onehot_f(filt_cnt_r);
            addr_r  <= addr_cnt_r;
            data_r  <= data_i;
            sel_r   <= filt_cnt_r;
        end else begin
            wr_en_r <= '0;
        end
    end

    assign data_ready_o = data_ready_r;
    assign bram_wr_en_o = wr_en_r;
    assign bram_addr_o  = addr_r;
    assign bram_data_o  = data_r;
    assign sel_filter_o = sel_r;
    assign bram_ready_o = bram_ready_r;
    assign load_done_o  = load_done_r;

endmodule

// File: doc/bram_load_ctrl.md
BRAM_LOAD_CTRL -- requirements
Module: bram_load_ctrl

Interface
REQ-001 SHALL have parameter NUMBER_SUPPORTED_FILTERS, default 30, number of per-filter BRAM banks filled per load.
REQ-002 SHALL have parameter BRAM_ADDR_WIDTH, default 11, BRAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, stream and BRAM word width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port general_rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port order_load_bram_i  input  1  start pulse for a load.
REQ-007 SHALL have port bram_addr_max_i  input  BRAM_ADDR_WIDTH  last address per bank, sampled at start.
REQ-008 SHALL have port data_valid_i  input  1  stream word valid.
REQ-009 SHALL have port data_i  input  DATA_WIDTH  stream word.
REQ-010 SHALL have port data_ready_o  output  1  block accepts a word this cycle.
REQ-011 SHALL have port bram_wr_en_o  output  NUMBER_SUPPORTED_FILTERS  one-hot bank write enable.
REQ-012 SHALL have port bram_addr_o  output  BRAM_ADDR_WIDTH  write address.
REQ-013 SHALL have port bram_data_o  output  DATA_WIDTH  write data.
REQ-014 SHALL have port sel_filter_o  output  $clog2(NUMBER_SUPPORTED_FILTERS)  current filter index.
REQ-015 SHALL have port bram_ready_o  output  1  high when BRAMs are owned by computation (not loading).
REQ-016 SHALL have port load_done_o  output  1  one-cycle pulse at load completion.

Function
REQ-017 SHALL implement FSM states IDLE, LATCH, LOAD, DONE.
REQ-018 IDLE -> LATCH SHALL occur when order_load_bram_i=1; otherwise the FSM stays in IDLE.
REQ-019 LATCH SHALL register bram_addr_max_i, clear both counters, and go to LOAD after one cycle.
REQ-020 data_ready_o SHALL be 1 only in LOAD; bram_ready_o SHALL be 1 only in IDLE.
REQ-021 A word transfer SHALL occur on data_valid_i & data_ready_o; no other cycle writes.
REQ-022 Write latency SHALL be one cycle: bram_wr_en_o bit sel_filter, bram_addr_o, and bram_data_o are registered from the transfer cycle; bram_wr_en_o is all-zero otherwise.
REQ-023 The address counter SHALL increment per transfer; at the latched max it SHALL wrap to 0 and the filter counter SHALL increment.
REQ-024 A transfer at filter NUMBER_SUPPORTED_FILTERS-1 and address = latched max SHALL move the FSM to DONE; data_ready_o SHALL be 0 from the next cycle.
REQ-025 DONE SHALL assert load_done_o for exactly one cycle, then return to IDLE.
REQ-026 Latched max = 0 SHALL write exactly one word per bank.
REQ-027 order_load_bram_i outside IDLE SHALL be ignored; a bram_addr_max_i change after LATCH SHALL have no effect.
REQ-028 Deasserted data_valid_i in LOAD SHALL hold both counters and all outputs except bram_wr_en_o, which is zero.
REQ-029 Total transfers per load SHALL be NUMBER_SUPPORTED_FILTERS*(max+1).

Reset
REQ-030 Reset low SHALL immediately force IDLE, clear the counters and the latched max, and set bram_wr_en_o=0, bram_addr_o=0, bram_data_o=0, sel_filter_o=0, data_ready_o=0, load_done_o=0, and bram_ready_o=1.
REQ-031 Reset mid-LOAD SHALL abandon the load without a load_done_o pulse; the next load SHALL restart at filter 0, address 0.

Configuration
REQ-032 Macro BRAM_LOAD_CTRL_ABORT_EN defined SHALL add input abort_i (1 bit); abort_i=1 in LATCH or LOAD SHALL return the FSM to IDLE next cycle, clear the counters, suppress the pending write enable and produce no load_done_o pulse.
REQ-033 With BRAM_LOAD_CTRL_ABORT_EN undefined, the abort_i port and its logic SHALL be absent, and a load SHALL end only via DONE or reset.

Verification (NUMBER_SUPPORTED_FILTERS=3, BRAM_ADDR_WIDTH=4)
REQ-034 Start with max=3 and continuous valid, data 0..11 -> 12 writes; bank0 addresses 0..3 hold 0..3, bank2 address 3 holds 11; load_done_o pulses once, then bram_ready_o=1.
REQ-035 Valid toggled every other cycle with max=1 -> 6 writes, no duplicated or skipped addresses, and bram_wr_en_o=0 on idle cycles.
REQ-036 Max=0 -> exactly 3 writes at address 0 with bram_wr_en_o = 001, 010, 100 in order.
REQ-037 Reset pulsed after 5 transfers -> outputs go to reset values immediately with no done pulse; a restart writes bank0 address 0 first.
REQ-038 Start pulse mid-LOAD and max changed to 7 after LATCH -> no effect; completes after 12 transfers (max=3).
REQ-039 With BRAM_LOAD_CTRL_ABORT_EN, abort_i at transfer 4 -> IDLE next cycle, no further writes, and no load_done_o pulse.
